// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the lane-width helper.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    // Number of byte-lane address bits on an XLEN-wide bus.
    function automatic int lane_bits(input int xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage

// File: rtl/lsu_bus_ctrl_lane_align.sv
// Combinational lane handling: byte enables, store replication, load
// extraction/extension and access legality checks.
module lsu_bus_ctrl_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]                 func,
    input  logic                       is_store,
    input  logic [lane_bits(XLEN)-1:0] lane,
    input  logic [XLEN-1:0]            rs2,
    input  logic [XLEN-1:0]            rdata,
    output logic [XLEN/8-1:0]          be,
    output logic [XLEN-1:0]            wdata,
    output logic [XLEN-1:0]            ldata,
    output logic                       misaligned,
    output logic                       illegal
);

    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] shifted;
    logic            sgn;

    always_comb begin
        shifted    = rdata >> {lane, 3'b000};
        sgn        = 1'b0;
        be         = '1;
        wdata      = rs2;
        ldata      = shifted;
        misaligned = 1'b0;
        case (func[1:0])
            LB[1:0]: begin
                be            = NB'(1) << lane;
                wdata         = {NB{rs2[7:0]}};
                sgn           = shifted[7] & ~func[2];
                ldata         = {XLEN{sgn}};
                ldata[7:0]    = shifted[7:0];
            end
            LH[1:0]: begin
                be            = NB'(3) << lane;
                wdata         = {(NB/2){rs2[15:0]}};
                sgn           = shifted[15] & ~func[2];
                ldata         = {XLEN{sgn}};
                ldata[15:0]   = shifted[15:0];
                misaligned    = lane[0];
            end
            LW[1:0]: begin
                be            = NB'(15) << lane;
                wdata         = {(NB/4){rs2[31:0]}};
                sgn           = shifted[31] & ~func[2];
                ldata         = {XLEN{sgn}};
                ldata[31:0]   = shifted[31:0];
                misaligned    = |lane[1:0];
            end
            default: begin
                misaligned    = |lane;
            end
        endcase
    end

    // Doubleword and LWU only exist on a 64-bit datapath.
    always_comb begin
        if (is_store)
            illegal = func[2] | ((XLEN == 32) && (func == SD));
        else
            illegal = (func == 3'b111) | ((XLEN == 32) && ((func == LD) || (func == LWU)));
    end

endmodule

// File: rtl/lsu_bus_ctrl.sv
// Load/store unit: takes one access from execute, runs it over the req/ack
// memory bus with a wait-state timeout and returns extended load data.
//
//   state | meaning
//   IDLE  | waiting for start; operands latched and checked on start
//   REQ   | bus request outstanding (or one dead cycle for a rejected access)
//   RESP  | done pulse, fault and register write-back
module lsu_bus_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                is_store,
    input  logic [2:0]          func,
    input  logic [4:0]          rd_in,
    input  logic [XLEN-1:0]     rs1_val,
    input  logic [XLEN-1:0]     rs2_val,
    input  logic [XLEN-1:0]     imm,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic                r_wen,
    output logic [4:0]          rd_out,
    output logic [XLEN-1:0]     r_data,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [XLEN/8-1:0]   m_be,
    output logic [XLEN-1:0]     m_wdata,
    input  logic                m_ack,
    input  logic [XLEN-1:0]     m_rdata
);

    localparam int L  = lane_bits(XLEN);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    lsu_state_e        state;
    logic [2:0]        func_q;
    logic              st_q;
    logic              err_q;
    logic [L-1:0]      lane_q;
    logic [4:0]        rd_q;
    logic [TW-1:0]     tmo_cnt;
    logic              tmo_hit;

    logic [ADDR_W-1:0] ea_next;
    logic              idle;
    logic [2:0]        al_func;
    logic              al_store;
    logic [L-1:0]      al_lane;
    logic [XLEN/8-1:0] al_be;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_ldata;
    logic              al_misaligned;
    logic              al_illegal;

    assign ea_next  = ADDR_W'(rs1_val + imm);
    assign idle     = (state == IDLE);
    // Checks run on the live operands at start, extraction on the latched ones.
    assign al_func  = idle ? func : func_q;
    assign al_store = idle ? is_store : st_q;
    assign al_lane  = idle ? ea_next[L-1:0] : lane_q;
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_cnt == '0);

    lsu_bus_ctrl_lane_align #(.XLEN(XLEN)) u_align (
        .func       (al_func),
        .is_store   (al_store),
        .lane       (al_lane),
        .rs2        (rs2_val),
        .rdata      (m_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .ldata      (al_ldata),
        .misaligned (al_misaligned),
        .illegal    (al_illegal)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            fault   <= 1'b0;
            r_wen   <= 1'b0;
            rd_out  <= '0;
            r_data  <= '0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_be    <= '0;
            m_wdata <= '0;
            func_q  <= '0;
            st_q    <= 1'b0;
            err_q   <= 1'b0;
            lane_q  <= '0;
            rd_q    <= '0;
            tmo_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        func_q  <= func;
                        st_q    <= is_store;
                        lane_q  <= ea_next[L-1:0];
                        rd_q    <= rd_in;
                        busy    <= 1'b1;
                        tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
                        err_q   <= al_illegal | al_misaligned;
                        // Rejected accesses still pass through REQ, without a
                        // bus request, so done always lands two cycles out.
                        state   <= REQ;
                        if (!(al_illegal | al_misaligned)) begin
                            m_req   <= 1'b1;
                            m_we    <= is_store;
                            m_addr  <= {ea_next[ADDR_W-1:L], {L{1'b0}}};
                            m_be    <= al_be;
                            m_wdata <= al_wdata;
                        end
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt - TW'(1);
                    if (err_q || m_ack || tmo_hit) begin
                        m_req <= 1'b0;
                        done  <= 1'b1;
                        fault <= err_q | ~m_ack;
                        state <= RESP;
                        if (!err_q && m_ack && !st_q) begin
                            r_wen  <= 1'b1;
                            rd_out <= rd_q;
                            r_data <= al_ldata;
                        end
                    end
                end
                RESP: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    r_wen <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: a 32-bit (timeout 4) and a 64-bit (timeout 16)
// instance driven by directed and random accesses against a reference model.
module tb_lsu_bus_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start32 = 1'b0, start64 = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  func = '0;
    logic [4:0]  rd_in = '0;
    logic [63:0] rs1 = '0, rs2 = '0, imm = '0;
    logic [63:0] mem_rdata = '0;
    logic        ack_drv = 1'b0;
    logic        sel64 = 1'b0;

    logic        busy32, done32, fault32, rwen32, req32, we32, ack32;
    logic [4:0]  rdout32;
    logic [31:0] rdat32, addr32, wdata32;
    logic [3:0]  be32;
    logic        busy64, done64, fault64, rwen64, req64, we64, ack64;
    logic [4:0]  rdout64;
    logic [63:0] rdat64, wdata64;
    logic [31:0] addr64;
    logic [7:0]  be64;

    logic        o_busy, o_done, o_fault, o_rwen, o_req, o_we;
    logic [4:0]  o_rdout;
    logic [63:0] o_rdat, o_wdata;
    logic [31:0] o_addr;
    logic [7:0]  o_be;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_rd [2];

    always #5 clk = ~clk;

    assign ack32 = ack_drv & ~sel64;
    assign ack64 = ack_drv & sel64;

    assign o_busy  = sel64 ? busy64  : busy32;
    assign o_done  = sel64 ? done64  : done32;
    assign o_fault = sel64 ? fault64 : fault32;
    assign o_rwen  = sel64 ? rwen64  : rwen32;
    assign o_req   = sel64 ? req64   : req32;
    assign o_we    = sel64 ? we64    : we32;
    assign o_rdout = sel64 ? rdout64 : rdout32;
    assign o_rdat  = sel64 ? rdat64  : {32'b0, rdat32};
    assign o_wdata = sel64 ? wdata64 : {32'b0, wdata32};
    assign o_addr  = sel64 ? addr64  : addr32;
    assign o_be    = sel64 ? be64    : {4'b0, be32};

    lsu_bus_ctrl #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut32 (
        .clk(clk), .rstn(rstn), .start(start32), .is_store(is_store), .func(func),
        .rd_in(rd_in), .rs1_val(rs1[31:0]), .rs2_val(rs2[31:0]), .imm(imm[31:0]),
        .busy(busy32), .done(done32), .fault(fault32), .r_wen(rwen32), .rd_out(rdout32),
        .r_data(rdat32), .m_req(req32), .m_we(we32), .m_addr(addr32), .m_be(be32),
        .m_wdata(wdata32), .m_ack(ack32), .m_rdata(mem_rdata[31:0])
    );

    lsu_bus_ctrl #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(16)) dut64 (
        .clk(clk), .rstn(rstn), .start(start64), .is_store(is_store), .func(func),
        .rd_in(rd_in), .rs1_val(rs1), .rs2_val(rs2), .imm(imm),
        .busy(busy64), .done(done64), .fault(fault64), .r_wen(rwen64), .rd_out(rdout64),
        .r_data(rdat64), .m_req(req64), .m_we(we64), .m_addr(addr64), .m_be(be64),
        .m_wdata(wdata64), .m_ack(ack64), .m_rdata(mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour from the access rules, in plain arithmetic.
    task automatic ref_model(input int xl, input bit st, input logic [2:0] f,
                             input logic [31:0] ea, input logic [63:0] b, input logic [63:0] word,
                             output bit bad, output logic [7:0] be, output logic [63:0] wd,
                             output logic [63:0] ld);
        int nb, bus, lane;
        bit illegal;
        logic [63:0] keep, v;
        nb   = 1 << f[1:0];
        bus  = xl / 8;
        lane = int'(ea % 32'(bus));
        if (st) illegal = f[2] || (xl == 32 && f[1:0] == 2'b11);
        else    illegal = (f == 3'b111) || (xl == 32 && (f == 3'b011 || f == 3'b110));
        bad = illegal || (ea % 32'(nb) != 0);
        be  = 8'(((1 << nb) - 1) << lane);
        wd  = '0;
        for (int i = 0; i < bus; i++) wd[8*i +: 8] = b[8*(i % nb) +: 8];
        keep = (nb == 8) ? '1 : ((64'd1 << (8*nb)) - 1);
        v = (word >> (8*lane)) & keep;
        if (!f[2] && nb < 8 && v[8*nb-1]) v = v | ~keep;
        if (xl == 32) v = v & 64'hFFFF_FFFF;
        ld = v;
    endtask

    task automatic run_acc(input bit s64, input bit st, input logic [2:0] f,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] im,
                           input logic [4:0] rd, input int waits, input logic [63:0] word,
                           input bit poke);
        int xl, tmo, exp_done, exp_nreq, nreq, idx;
        bit bad, exp_fault, exp_wen, got;
        logic [31:0] ea;
        logic [7:0]  be;
        logic [63:0] wd, ld;
        xl  = s64 ? 64 : 32;
        tmo = s64 ? 16 : 4;
        idx = s64 ? 1 : 0;
        ea  = 32'(a + im);
        ref_model(xl, st, f, ea, b, word, bad, be, wd, ld);
        if (bad) begin
            exp_done = 2; exp_nreq = 0; exp_fault = 1;
        end else if (waits >= tmo) begin
            exp_done = tmo + 1; exp_nreq = tmo; exp_fault = 1;
        end else begin
            exp_done = waits + 2; exp_nreq = waits + 1; exp_fault = 0;
        end
        exp_wen = !st && !exp_fault;

        sel64 = s64;
        @(negedge clk);
        is_store = st; func = f; rs1 = a; rs2 = b; imm = im; rd_in = rd; mem_rdata = word;
        if (s64) start64 = 1'b1; else start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0; start64 = 1'b0;
        nreq = 0; got = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            if (c == 2) begin start32 = 1'b0; start64 = 1'b0; end
            if (c == 1) begin
                check_eq("busy", 64'(o_busy), 64'd1);
                if (poke) begin
                    rs1 = a ^ 64'h40;
                    if (s64) start64 = 1'b1; else start32 = 1'b1;
                end
            end
            if (o_req) begin
                nreq++;
                if (nreq == 1) begin
                    check_eq("m_addr", 64'(o_addr), 64'(ea - (ea % 32'(xl / 8))));
                    check_eq("m_we", 64'(o_we), 64'(st));
                    if (st) begin
                        check_eq("m_be", 64'(o_be), 64'(be));
                        check_eq("m_wdata", o_wdata, wd);
                    end
                end
                ack_drv = (nreq == waits + 1);
            end else begin
                ack_drv = 1'b0;
            end
            if (o_done) begin
                got = 1;
                check_eq("done_cycle", 64'(c), 64'(exp_done));
                check_eq("req_cycles", 64'(nreq), 64'(exp_nreq));
                check_eq("fault", 64'(o_fault), 64'(exp_fault));
                check_eq("r_wen", 64'(o_rwen), 64'(exp_wen));
                if (exp_wen) begin
                    check_eq("rd_out", 64'(o_rdout), 64'(rd));
                    exp_rd[idx] = ld;
                end
                check_eq("r_data", o_rdat, exp_rd[idx]);
            end else begin
                check_eq("fault_idle", 64'(o_fault), 64'd0);
            end
            @(negedge clk);
        end
        ack_drv = 1'b0;
        start32 = 1'b0; start64 = 1'b0;
        check_eq("done_seen", 64'(got), 64'd1);
        check_eq("done_pulse", 64'(o_done), 64'd0);
        check_eq("busy_after", 64'(o_busy), 64'd0);
    endtask

    initial begin
        logic [11:0] i12;
        logic [63:0] a, b, word;
        bit s64, st;
        int w;

        exp_rd[0] = '0;
        exp_rd[1] = '0;
        #12;
        check_eq("rst_busy32", 64'(busy32), 64'd0);
        check_eq("rst_req32", 64'(req32), 64'd0);
        check_eq("rst_done64", 64'(done64), 64'd0);
        check_eq("rst_req64", 64'(req64), 64'd0);
        check_eq("rst_rdata64", rdat64, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        run_acc(0, 1, SB,  64'h1000, 64'hAABBCCDD, 64'd3, 5'd1, 0, 64'h0, 0);
        run_acc(0, 0, LB,  64'h2000, 64'h0, 64'd2, 5'd7, 3, 64'h0080_0000, 0);
        run_acc(0, 0, LBU, 64'h2000, 64'h0, 64'd2, 5'd8, 3, 64'h0080_0000, 0);
        run_acc(0, 0, LW,  64'h1000, 64'h0, 64'd1, 5'd9, 0, 64'h1234_5678, 0);
        run_acc(0, 0, LH,  64'h1000, 64'h0, 64'd3, 5'd9, 0, 64'h1234_5678, 0);
        run_acc(0, 0, LW,  64'h1010, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 5'd3, 100, 64'hCAFE_F00D, 0);
        run_acc(0, 0, LW,  64'h1010, 64'h0, 64'd0, 5'd3, 3, 64'hCAFE_F00D, 0);
        run_acc(0, 0, LHU, 64'h1000, 64'h0, 64'd2, 5'd4, 0, 64'h8001_0000, 1);

        // Reset while a request is outstanding.
        sel64 = 1'b0;
        @(negedge clk);
        func = LW; is_store = 1'b0; rs1 = 64'h3000; imm = '0; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        check_eq("pre_rst_req", 64'(o_req), 64'd1);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check_eq("rst_req", 64'(o_req), 64'd0);
        check_eq("rst_busy", 64'(o_busy), 64'd0);
        check_eq("rst_done", 64'(o_done), 64'd0);
        check_eq("rst_rdata", o_rdat, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        repeat (2) begin
            @(negedge clk);
            check_eq("rst_nodone", 64'(o_done), 64'd0);
        end
        run_acc(0, 0, LW, 64'h3000, 64'h0, 64'd4, 5'd11, 1, 64'h89AB_CDEF, 0);

        run_acc(1, 0, LD,  64'h0, 64'h0, 64'd8, 5'd12, 0, 64'h8877_6655_4433_2211, 0);
        run_acc(1, 0, LWU, 64'h0, 64'h0, 64'hC, 5'd13, 2, 64'h8877_6655_4433_2211, 0);
        run_acc(1, 1, SH,  64'h100, 64'h1234_5678_9ABC_DEF0, 64'd6, 5'd0, 1, 64'h0, 0);
        run_acc(1, 0, LW,  64'h100, 64'h0, 64'd4, 5'd14, 20, 64'h0, 0);

        for (int n = 0; n < 80; n++) begin
            s64  = $urandom_range(0, 1);
            st   = $urandom_range(0, 1);
            a    = {$urandom, $urandom};
            b    = {$urandom, $urandom};
            word = {$urandom, $urandom};
            i12  = 12'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                a[2:0]   = '0;
                i12[2:0] = '0;
            end
            if (s64) w = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
            else     w = $urandom_range(0, 5);
            run_acc(s64, st, 3'($urandom_range(0, 7)), a, b, {{52{i12[11]}}, i12},
                    5'($urandom), w, word, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
